// File: rtl/layer_mem_host_pkg.sv
// Shared constants and state encoding for the layer memory host.
// Widths here fix the port sizes of layer_mem_host and the RAM depths.
package layer_mem_host_pkg;

    localparam int DW        = 13;
    localparam int IMG_WORDS = 4096;
    localparam int L0_WORDS  = 4096;
    localparam int L1_WORDS  = 1024;
    localparam int IAW       = 12;
    localparam int L1AW      = 10;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_DUMP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/layer_mem_host_ram.sv
// Generic RAM: combinational read, write on the rising edge.
// Contents are never reset.
module layer_ram
    import layer_mem_host_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int W     = DW,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/layer_mem_host.sv
// Host side of the conv engine: image load, layer RAMs and L1 dump.
// Sequencing is LOAD -> START -> RUN -> DUMP -> DONE.
module layer_mem_host
    import layer_mem_host_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            img_valid,
    output logic            img_ready,
    input  logic [DW-1:0]   img_data,
    output logic            ready,
    input  logic            busy,
    input  logic [IAW-1:0]  iaddr,
    output logic [DW-1:0]   idata,
    input  logic            cwr,
    input  logic            crd,
    input  logic            csel,
    input  logic [IAW-1:0]  caddr_wr,
    input  logic [DW-1:0]   cdata_wr,
    input  logic [IAW-1:0]  caddr_rd,
    output logic [DW-1:0]   cdata_rd,
    output logic            dump_valid,
    input  logic            dump_ready,
    output logic [L1AW-1:0] dump_addr,
    output logic [DW-1:0]   dump_data,
    output logic            done,
    output logic            err,
    input  logic            restart
);

    localparam logic [IAW-1:0]  LD_LAST = IAW'(IMG_WORDS - 1);
    localparam logic [L1AW-1:0] DP_LAST = L1AW'(L1_WORDS - 1);

    state_t          state_q, state_d;
    logic [IAW-1:0]  ld_cnt_q, ld_cnt_d;
    logic [L1AW-1:0] dp_cnt_q, dp_cnt_d;
    logic            err_q, err_d;

    logic            img_we, l0_we, l1_we;
    logic            wr_oor, rd_oor;
    logic [DW-1:0]   l0_rd, l1_rd;

    assign wr_oor = cwr && csel && (caddr_wr[IAW-1:L1AW] != '0);
    assign rd_oor = crd && csel && (caddr_rd[IAW-1:L1AW] != '0);
    assign img_we = img_valid && img_ready;
    assign l0_we  = cwr && !csel;
    assign l1_we  = cwr && csel && !wr_oor;

    always_comb begin
        state_d    = state_q;
        ld_cnt_d   = ld_cnt_q;
        dp_cnt_d   = dp_cnt_q;
        img_ready  = 1'b0;
        ready      = 1'b0;
        dump_valid = 1'b0;
        done       = 1'b0;
        err_d      = err_q || wr_oor || rd_oor;
        unique case (state_q)
            ST_LOAD: begin
                img_ready = 1'b1;
                if (img_valid) begin
                    ld_cnt_d = ld_cnt_q + 1'b1;
                    if (ld_cnt_q == LD_LAST) begin
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                ready = 1'b1;
                if (busy) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!busy) begin
                    state_d = ST_DUMP;
                end
            end
            ST_DUMP: begin
                dump_valid = 1'b1;
                if (dump_ready) begin
                    dp_cnt_d = dp_cnt_q + 1'b1;
                    if (dp_cnt_q == DP_LAST) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (restart) begin
                    ld_cnt_d = '0;
                    dp_cnt_d = '0;
                    state_d  = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_LOAD;
            ld_cnt_q <= '0;
            dp_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
            dp_cnt_q <= dp_cnt_d;
            err_q    <= err_d;
        end
    end

    layer_ram #(.DEPTH(IMG_WORDS), .W(DW), .AW(IAW)) u_img (
        .clk   (clk),
        .we    (img_we),
        .waddr (ld_cnt_q),
        .wdata (img_data),
        .raddr (iaddr),
        .rdata (idata)
    );

    layer_ram #(.DEPTH(L0_WORDS), .W(DW), .AW(IAW)) u_l0 (
        .clk   (clk),
        .we    (l0_we),
        .waddr (caddr_wr),
        .wdata (cdata_wr),
        .raddr (caddr_rd),
        .rdata (l0_rd)
    );

    layer_ram #(.DEPTH(L1_WORDS), .W(DW), .AW(L1AW)) u_l1 (
        .clk   (clk),
        .we    (l1_we),
        .waddr (caddr_wr[L1AW-1:0]),
        .wdata (cdata_wr),
        .raddr (caddr_rd[L1AW-1:0]),
        .rdata (l1_rd)
    );

    // Mirror of L1 so the dump stream never contends with host reads.
    layer_ram #(.DEPTH(L1_WORDS), .W(DW), .AW(L1AW)) u_l1_dump (
        .clk   (clk),
        .we    (l1_we),
        .waddr (caddr_wr[L1AW-1:0]),
        .wdata (cdata_wr),
        .raddr (dp_cnt_q),
        .rdata (dump_data)
    );

    assign cdata_rd  = !crd ? '0 : (csel ? l1_rd : l0_rd);
    assign dump_addr = dp_cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_layer_mem_host.sv
// Self-checking bench for layer_mem_host.
// Host RAM vectors from a table; dump beats checked against a queue.
module tb_layer_mem_host;
    import layer_mem_host_pkg::*;

    logic            clk, reset;
    logic            img_valid, img_ready;
    logic [DW-1:0]   img_data;
    logic            ready, busy;
    logic [IAW-1:0]  iaddr;
    logic [DW-1:0]   idata;
    logic            cwr, crd, csel;
    logic [IAW-1:0]  caddr_wr, caddr_rd;
    logic [DW-1:0]   cdata_wr, cdata_rd;
    logic            dump_valid, dump_ready;
    logic [L1AW-1:0] dump_addr;
    logic [DW-1:0]   dump_data;
    logic            done, err, restart;

    layer_mem_host dut (
        .clk(clk), .reset(reset),
        .img_valid(img_valid), .img_ready(img_ready), .img_data(img_data),
        .ready(ready), .busy(busy),
        .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .crd(crd), .csel(csel),
        .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data),
        .done(done), .err(err), .restart(restart)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic           wr, rd, sel;
        logic [IAW-1:0] wa;
        logic [DW-1:0]  wd;
        logic [IAW-1:0] ra;
        logic [DW-1:0]  erd;
        logic           eerr;
    } vec_t;

    typedef struct packed {
        logic [L1AW-1:0] a;
        logic [DW-1:0]   d;
    } beat_t;

    vec_t          vt [14];
    beat_t         sbq [$];
    logic [DW-1:0] l1m [L1_WORDS];
    int            n_cmp, n_bad;
    bit            stopped;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_image();
        int i;
        i = 0;
        while (i < IMG_WORDS) begin
            img_valid = ($urandom_range(0, 7) != 0);
            img_data  = DW'(i & 'hFFF);
            tick();
            if (img_valid) i++;
        end
        img_valid = 1'b0;
    endtask

    task automatic push_dump();
        for (int i = 0; i < L1_WORDS; i++)
            sbq.push_back('{a: L1AW'(i), d: l1m[i]});
    endtask

    task automatic run_dump(input int stop_at, output bit hit);
        int    beats;
        beat_t b;
        beats = 0;
        hit   = 1'b0;
        for (int c = 0; c < 4000 && beats < L1_WORDS; c++) begin
            dump_ready = ($urandom_range(0, 3) != 0);
            #1;
            chk("dump_valid", dump_valid, 1);
            if (stop_at >= 0 && int'(dump_addr) == stop_at) begin
                hit = 1'b1;
                return;
            end
            if (dump_ready && sbq.size() > 0) begin
                b = sbq.pop_front();
                chk("dump_addr", dump_addr, b.a);
                chk("dump_data", dump_data, b.d);
                beats++;
            end
            tick();
        end
        if (beats < L1_WORDS) chk("dump_timeout", beats, L1_WORDS);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{1'b1, 1'b0, 1'b0, 12'h7FF, 13'h0AAA, 12'h000, 13'h0000, 1'b0};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 12'h7FF, 13'h1234, 12'h7FF, 13'h0AAA, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 12'h000, 13'h0000, 12'h7FF, 13'h1234, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 12'h123, 13'h0555, 12'h000, 13'h0000, 1'b0};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 12'h123, 13'h0666, 12'h123, 13'h0555, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 12'h000, 13'h0000, 12'h123, 13'h0666, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 1'b1, 12'h000, 13'h0111, 12'h000, 13'h0000, 1'b0};
        vt[7]  = '{1'b1, 1'b1, 1'b1, 12'h005, 13'h00CD, 12'h000, 13'h0111, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 12'h005, 13'h00AB, 12'h000, 13'h0000, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 1'b1, 12'h000, 13'h0000, 12'h005, 13'h00CD, 1'b0};
        vt[10] = '{1'b0, 1'b1, 1'b0, 12'h000, 13'h0000, 12'h005, 13'h00AB, 1'b0};
        vt[11] = '{1'b1, 1'b0, 1'b1, 12'h400, 13'h1FFF, 12'h000, 13'h0000, 1'b1};
        vt[12] = '{1'b0, 1'b1, 1'b1, 12'h000, 13'h0000, 12'h000, 13'h0111, 1'b1};
        vt[13] = '{1'b0, 1'b1, 1'b1, 12'h000, 13'h0000, 12'h405, 13'h00CD, 1'b1};

        n_cmp = 0; n_bad = 0;
        reset = 1'b1; img_valid = 1'b0; img_data = '0; busy = 1'b0;
        iaddr = '0; cwr = 1'b0; crd = 1'b0; csel = 1'b0;
        caddr_wr = '0; cdata_wr = '0; caddr_rd = '0;
        dump_ready = 1'b0; restart = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_img_ready", img_ready, 1);
        chk("rst_ready", ready, 0);
        chk("rst_dump_valid", dump_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);

        load_image();
        iaddr = 12'h041; #1;
        chk("idata_041", idata, 13'h041);
        iaddr = 12'hFFF; #1;
        chk("idata_fff", idata, 13'hFFF);
        chk("start_img_ready", img_ready, 0);
        chk("start_ready", ready, 1);
        tick();
        chk("start_hold_ready", ready, 1);
        busy = 1'b1;
        tick();
        chk("run_ready", ready, 0);
        chk("run_dump_valid", dump_valid, 0);

        img_valid = 1'b1; img_data = 13'h1ABC;
        #1 chk("run_img_ready", img_ready, 0);
        tick();
        img_valid = 1'b0; iaddr = 12'h000; #1;
        chk("ignored_img", idata, 13'h000);

        for (int i = 0; i < 14; i++) begin
            cwr = vt[i].wr; crd = vt[i].rd; csel = vt[i].sel;
            caddr_wr = vt[i].wa; cdata_wr = vt[i].wd; caddr_rd = vt[i].ra;
            #2;
            chk($sformatf("vec%0d_rd", i), cdata_rd, vt[i].erd);
            tick();
            chk($sformatf("vec%0d_err", i), err, vt[i].eerr);
        end
        cwr = 1'b0; crd = 1'b0;

        cwr = 1'b1; csel = 1'b1;
        for (int i = 0; i < L1_WORDS; i++) begin
            caddr_wr = IAW'(i);
            cdata_wr = DW'((i * 37 + 5) & 'h1FFF);
            l1m[i]   = cdata_wr;
            tick();
        end
        cwr = 1'b0; csel = 1'b0;

        busy = 1'b0; dump_ready = 1'b0;
        push_dump();
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_valid", dump_valid, 1);
            chk("stall_addr", dump_addr, 0);
            chk("stall_data", dump_data, sbq[0].d);
            tick();
        end
        run_dump(-1, stopped);
        dump_ready = 1'b0; #1;
        chk("done", done, 1);
        chk("done_dump_valid", dump_valid, 0);
        chk("done_img_ready", img_ready, 0);

        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_img_ready", img_ready, 1);
        chk("restart_done", done, 0);
        chk("restart_err_sticky", err, 1);
        iaddr = 12'h041; crd = 1'b1; csel = 1'b0; caddr_rd = 12'h7FF; #1;
        chk("keep_img", idata, 13'h041);
        chk("keep_l0", cdata_rd, 13'h1234);
        crd = 1'b0;

        load_image();
        busy = 1'b1;
        tick();
        busy = 1'b0;
        push_dump();
        tick();
        run_dump(500, stopped);
        chk("reached_500", stopped, 1);
        chk("pre_reset_err", err, 1);
        reset = 1'b1;
        tick();
        chk("mid_rst_img_ready", img_ready, 1);
        chk("mid_rst_dump_valid", dump_valid, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_done", done, 0);
        reset = 1'b0; dump_ready = 1'b0;
        sbq.delete();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
